// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide sequencer.
package mdu_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_ITER  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } mdu_state_e;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// acc holds {hi[32:0], lo[31:0]}: product/multiplier for MUL, remainder/quotient for DIV.
module mdu_step
  import mdu_pkg::*;
(
  input  logic              is_div,
  input  logic [2*XLEN:0]   acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN:0]   acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  always_comb begin
    sum      = acc[2*XLEN:XLEN] + {1'b0, opnd};
    shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    trial    = shifted - {1'b0, opnd};
    acc_next = acc;
    if (is_div) begin
      // trial[XLEN] set means the subtraction went negative: keep the shifted remainder.
      acc_next = {(trial[XLEN] ? shifted : trial), acc[XLEN-2:0], ~trial[XLEN]};
    end else if (acc[0]) begin
      acc_next = {1'b0, sum, acc[XLEN-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*XLEN:XLEN], acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide sequencer: one bit per cycle over mdu_step, valid/ready in and out.
// Optional MDU_EARLY_OUT_EN skips the iterations for divide-by-zero, signed overflow and zero multiplies.
module mdu_sequencer #(
  parameter int XLEN  = 32,
  parameter int ITERS = XLEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [2:0]           op,
  input  logic [XLEN-1:0]      a,
  input  logic [XLEN-1:0]      b,
  input  logic                 kill,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [XLEN-1:0]      result,
  output logic                 busy,
  output mdu_pkg::mdu_state_e  dbg_state
);
  import mdu_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid && ready; start is only
  // taken in IDLE, and result_valid/result stay stable in DONE until result_ready.

  localparam int CW = $clog2(ITERS);

  mdu_state_e      state;
  mdu_op_e         op_q;
  logic [XLEN-1:0] a_q, b_q, opnd_q, res_q;
  logic [2*XLEN:0] acc_q, acc_nx;
  logic [CW-1:0]   cnt_q;
  logic            neg_a_q, neg_b_q, rv_q;

  logic            is_div, sgn_a, sgn_b, div0, ovf, early;
  logic [XLEN-1:0] mag_a, mag_b, fix_res;
  logic [2*XLEN-1:0] prod;

  assign is_div = op_q[2];

  always_comb begin
    sgn_a = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
    sgn_b = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
    mag_a = cond_neg(a_q, sgn_a & a_q[XLEN-1]);
    mag_b = cond_neg(b_q, sgn_b & b_q[XLEN-1]);
    div0  = (b_q == '0);
    ovf   = (a_q == INT_MIN) && (b_q == '1) && ((op_q == OP_DIV) || (op_q == OP_REM));
`ifdef MDU_EARLY_OUT_EN
    early = is_div ? (div0 || ovf) : ((a_q == '0) || (b_q == '0));
`else
    early = 1'b0;
`endif
    prod = acc_q[2*XLEN-1:0];
    if (neg_a_q ^ neg_b_q) prod = -prod;
    case (op_q)
      OP_MUL:                       fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:
        fix_res = div0 ? DIV0_QUOT : ovf ? INT_MIN : cond_neg(acc_q[XLEN-1:0], neg_a_q ^ neg_b_q);
      default:
        fix_res = div0 ? a_q : ovf ? '0 : cond_neg(acc_q[2*XLEN-1:XLEN], neg_a_q);
    endcase
  end

  mdu_step u_step (
    .is_div   (is_div),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (acc_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= OP_MUL;
      a_q     <= '0;
      b_q     <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      res_q   <= '0;
      rv_q    <= 1'b0;
    end else if (kill && state != S_IDLE) begin
      state <= S_IDLE;
      rv_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid && !kill) begin
            op_q  <= mdu_op_e'(op);
            a_q   <= a;
            b_q   <= b;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          neg_a_q <= sgn_a & a_q[XLEN-1];
          neg_b_q <= sgn_b & b_q[XLEN-1];
          opnd_q  <= is_div ? mag_b : mag_a;
          // A skipped zero multiply must still read back as a zero product in FIXUP.
          acc_q   <= early ? '0 : {{(XLEN+1){1'b0}}, (is_div ? mag_a : mag_b)};
          cnt_q   <= CW'(ITERS - 1);
          state   <= early ? S_FIXUP : S_ITER;
        end
        S_ITER: begin
          acc_q <= acc_nx;
          if (cnt_q == '0) state <= S_FIXUP;
          else             cnt_q <= cnt_q - 1'b1;
        end
        S_FIXUP: begin
          res_q <= fix_res;
          rv_q  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          if (result_ready) begin
            rv_q  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign start_ready  = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign result_valid = rv_q;
  assign result       = res_q;
  assign dbg_state    = state;

endmodule
